// File: rtl/pattern_select_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_select_ctrl
//
// Upstream control stage for the VGA test pattern generator. The two raw board
// select inputs are synchronised and debounced, the debounced code is mapped to
// the 3-bit pattern code used by test_pattern_gen, and a new pattern is only
// committed through a small IDLE/PENDING/APPLY controller so the picture never
// switches mid-frame.
//
// Optional feature macro: PATSEL_FRAME_ALIGN_EN
//   defined   : a pending change is applied at the first cycle of vertical
//               blanking (falling edge of i_vsync).
//   undefined : a pending change is applied on the cycle after it is seen;
//               i_vsync is ignored and no vsync history register exists.
//
// Ports:
//   i_clk              pixel clock (24 MHz PLL output)
//   i_rst              asynchronous, active-high reset
//   i_sel0             raw select input, MSB of select code (asynchronous)
//   i_sel1             raw select input, LSB of select code (asynchronous)
//   i_vsync            1 during active rows, 0 during vertical blanking
//   o_pattern          pattern code to test_pattern_gen
//   o_pattern_changed  one-cycle pulse in the cycle o_pattern takes a new value
//   o_sel_stable       debounced select code {sel0, sel1}
// -----------------------------------------------------------------------------
module pattern_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sel0,
    input  logic       i_sel1,
    input  logic       i_vsync,
    output logic [2:0] o_pattern,
    output logic       o_pattern_changed,
    output logic [1:0] o_sel_stable
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_APPLY
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    function automatic logic [2:0] map_code(input logic [1:0] code);
        logic [2:0] pat;
        case (code)
            2'b00:   pat = 3'b001;
            2'b01:   pat = 3'b010;
            2'b10:   pat = 3'b100;
            default: pat = 3'b101;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // Two-flop synchroniser per select input, packed as {sel0, sel1}
    // ------------------------------------------------------------------
    logic [1:0] sync_meta;
    logic [1:0] sync_code;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // two synchroniser stages into one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_meta <= 2'b00;
            sync_code <= 2'b00;
        end else begin
            sync_meta <= {i_sel0, i_sel1};
            sync_code <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a code is accepted once it has been the candidate for
    // DEBOUNCE_CYCLES consecutive clocks (counter saturates at the top).
    // ------------------------------------------------------------------
    logic [1:0]           candidate;
    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            candidate    <= 2'b00;
            count        <= '0;
            o_sel_stable <= 2'b00;
        end else begin
            if (sync_code != candidate) begin
                candidate <= sync_code;
                count     <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end

            if ((count == CNT_MAX) && (candidate != o_sel_stable)) begin
                o_sel_stable <= candidate;
            end
        end
    end

    // ------------------------------------------------------------------
    // Apply condition for a pending change
    // ------------------------------------------------------------------
    logic advance;

`ifdef PATSEL_FRAME_ALIGN_EN
    logic vs_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= i_vsync;
        end
    end

    // First cycle of vertical blanking.
    assign advance = vs_d & ~i_vsync;
`else
    logic unused_vsync;

    assign unused_vsync = i_vsync;
    assign advance      = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Apply controller
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_next;
    logic [1:0] applied_code;
    logic [2:0] pattern_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            applied_code <= 2'b00;
            pattern_reg  <= 3'b001;
        end else begin
            state <= state_next;
            // Commit whatever stable code is present during the APPLY cycle.
            if (state == S_APPLY) begin
                applied_code <= o_sel_stable;
                pattern_reg  <= map_code(o_sel_stable);
            end
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next        = state;
        o_pattern         = pattern_reg;
        o_pattern_changed = 1'b0;
        case (state)
            S_IDLE: begin
                if (o_sel_stable != applied_code) begin
                    state_next = S_PENDING;
                end
            end
            S_PENDING: begin
                if (o_sel_stable == applied_code) begin
                    state_next = S_IDLE;
                end else if (advance) begin
                    state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                // The new pattern is visible in the same cycle as the pulse;
                // pattern_reg catches up on the following edge.
                o_pattern         = map_code(o_sel_stable);
                o_pattern_changed = 1'b1;
                state_next        = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pattern_select_ctrl
//
// Directed scenarios followed by a random select sequence, with every cycle
// compared against a behavioural model that works from the sampled input
// history (a window of raw samples for the debounce, a pending/apply flag
// pair for frame alignment). DEBOUNCE_CYCLES = 16, vsync period 200 clocks
// with 20 clocks low.
// -----------------------------------------------------------------------------
module tb_pattern_select_ctrl;

    localparam int D = 16;

`ifdef PATSEL_FRAME_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    localparam logic [2:0] PAT_OF [4] = '{3'b001, 3'b010, 3'b100, 3'b101};

    logic       clk;
    logic       rst;
    logic       sel0;
    logic       sel1;
    logic       vsync;
    logic [2:0] o_pattern;
    logic       o_pattern_changed;
    logic [1:0] o_sel_stable;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_cnt;
    bit saw_010;

    pattern_select_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (5)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_sel0            (sel0),
        .i_sel1            (sel1),
        .i_vsync           (vsync),
        .o_pattern         (o_pattern),
        .o_pattern_changed (o_pattern_changed),
        .o_sel_stable      (o_sel_stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame timing: 180 active clocks (vsync high), 20 blanking clocks.
    initial begin
        int vcnt;
        vcnt  = 0;
        vsync = 1'b1;
        forever begin
            @(negedge clk);
            vcnt  = (vcnt == 199) ? 0 : vcnt + 1;
            vsync = (vcnt < 180);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [1:0] hist [D+3];   // hist[0] is the newest raw sample
    logic [1:0] m_stable;
    logic [1:0] m_applied;
    bit         m_pending;
    bit         m_apply;
    bit         m_vs;
    logic [2:0] m_pat;
    bit         m_chg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D + 3; i++) hist[i] = 2'b00;
            m_stable  = 2'b00;
            m_applied = 2'b00;
            m_pending = 1'b0;
            m_apply   = 1'b0;
            m_vs      = 1'b0;
            m_pat     = 3'b001;
            m_chg     = 1'b0;
        end else begin
            bit blank;
            bit same;
            blank = m_vs & ~vsync;
            m_vs  = vsync;

            // Decisions use the values present in the cycle just ended.
            if (m_apply) begin
                m_applied = m_stable;
                m_apply   = 1'b0;
            end else if (m_pending) begin
                if (m_stable == m_applied) begin
                    m_pending = 1'b0;
                end else if (ALIGN ? blank : 1'b1) begin
                    m_pending = 1'b0;
                    m_apply   = 1'b1;
                end
            end else if (m_stable != m_applied) begin
                m_pending = 1'b1;
            end

            // A code reaches o_sel_stable once the synchronised input has
            // held it for D consecutive cycles; the raw samples three to
            // D+2 edges back are exactly that window.
            for (int i = D + 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {sel0, sel1};
            same = 1'b1;
            for (int i = 3; i < D + 3; i++) if (hist[i] != hist[3]) same = 1'b0;
            if (same) m_stable = hist[3];

            m_chg = m_apply;
            m_pat = m_apply ? PAT_OF[m_stable] : PAT_OF[m_applied];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_sel_stable", 32'(o_sel_stable), 32'(m_stable));
            check("model_pattern", 32'(o_pattern), 32'(m_pat));
            check("model_changed", 32'(o_pattern_changed), 32'(m_chg));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_pattern_changed) pulse_cnt++;
            if (o_pattern == 3'b010) saw_010 = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        sel0 = 1'b0;
        sel1 = 1'b0;
        run_cycles(3);
        rst = 1'b0;
    endtask

    task automatic wait_vsync_rise();
        int n;
        n = 0;
        while (vsync !== 1'b0 && n < 400) begin @(negedge clk); #1; n++; end
        while (vsync !== 1'b1 && n < 400) begin @(negedge clk); #1; n++; end
        check("vsync_rise_wait", 32'(vsync), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        sel0      = 1'b0;
        sel1      = 1'b0;
        pulse_cnt = 0;
        saw_010   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_pattern", 32'(o_pattern), 32'h1);
        check("reset_sel_stable", 32'(o_sel_stable), 32'h0);
        check("reset_changed", 32'(o_pattern_changed), 32'h0);
        rst = 1'b0;

        // 00 -> 10 held
        {sel0, sel1} = 2'b10;
        n = 0;
        do begin @(negedge clk); n++; end while (o_sel_stable !== 2'b10 && n < 100);
        check("stable_latency", 32'(n), 32'd19);
        n = 0;
        while (!o_pattern_changed && n < 500) begin @(negedge clk); n++; end
        check("b_pulse_seen", 32'(o_pattern_changed), 32'd1);
        check("b_pattern", 32'(o_pattern), 32'h4);
        pulse_cnt = 0;
        run_cycles(300);
        check("b_single_pulse", 32'(pulse_cnt), 32'd0);
        check("b_pattern_hold", 32'(o_pattern), 32'h4);

        // Reset mid-debounce, observed before any clock edge
        {sel0, sel1} = 2'b11;
        run_cycles(10);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pattern", 32'(o_pattern), 32'h1);
        check("midrst_sel_stable", 32'(o_sel_stable), 32'h0);
        check("midrst_changed", 32'(o_pattern_changed), 32'h0);
        @(negedge clk);
        {sel0, sel1} = 2'b00;
        run_cycles(3);
        rst = 1'b0;

        // Glitch shorter than the debounce window
        run_cycles(5);
        pulse_cnt = 0;
        {sel0, sel1} = 2'b01;
        run_cycles(10);
        {sel0, sel1} = 2'b00;
        run_cycles(60);
        check("glitch_sel_stable", 32'(o_sel_stable), 32'h0);
        check("glitch_pattern", 32'(o_pattern), 32'h1);
        check("glitch_pulses", 32'(pulse_cnt), 32'd0);

        // 00 -> 11, end-to-end latency
        {sel0, sel1} = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (o_pattern !== 3'b101 && n < 600);
        check("e_pattern", 32'(o_pattern), 32'h5);
`ifndef PATSEL_FRAME_ALIGN_EN
        check("e_latency", 32'(n), 32'd21);
`endif
        do_reset();

        // 00 -> 01 -> 11 within one active period
        wait_vsync_rise();
        pulse_cnt = 0;
        saw_010   = 1'b0;
        {sel0, sel1} = 2'b01;
        run_cycles(30);
        {sel0, sel1} = 2'b11;
        run_cycles(400);
        check("f_pattern", 32'(o_pattern), 32'h5);
`ifdef PATSEL_FRAME_ALIGN_EN
        check("f_pulses", 32'(pulse_cnt), 32'd1);
        check("f_saw_010", 32'(saw_010), 32'd0);
`else
        check("f_pulses", 32'(pulse_cnt), 32'd2);
        check("f_saw_010", 32'(saw_010), 32'd1);
`endif
        do_reset();

        // 00 -> 01 -> 00 within one active period
        wait_vsync_rise();
        pulse_cnt = 0;
        {sel0, sel1} = 2'b01;
        run_cycles(25);
        {sel0, sel1} = 2'b00;
        run_cycles(420);
        check("g_pattern", 32'(o_pattern), 32'h1);
`ifdef PATSEL_FRAME_ALIGN_EN
        check("g_pulses", 32'(pulse_cnt), 32'd0);
`else
        check("g_pulses", 32'(pulse_cnt), 32'd2);
`endif

        // Random select sequence: mix of glitches and settled values
        for (int s = 0; s < 40; s++) begin
            {sel0, sel1} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) run_cycles($urandom_range(1, 12));
            else                           run_cycles($urandom_range(17, 60));
        end
        run_cycles(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_select_ctrl.md
Name: pattern_select_ctrl

Overview:
- Upstream control stage for the VGA test pattern generator.
- Synchronises and debounces the two board select inputs (sel0, sel1), then maps the result to the 3-bit pattern code consumed by test_pattern_gen.
- Applies a pattern change only at the start of vertical blanking, so a frame never shows two patterns.
- Runs on the 24 MHz pixel clock (PLL output).

Parameters:
- DEBOUNCE_CYCLES, 240000, consecutive stable clocks required before a select value is accepted (10 ms at 24 MHz); must be >= 2.
- CNT_WIDTH, 18, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- i_clk  in  1  pixel clock (24 MHz PLL output)
- i_rst  in  1  reset; asynchronous, active-high
- i_sel0  in  1  raw select input, MSB of select code; asynchronous to i_clk
- i_sel1  in  1  raw select input, LSB of select code; asynchronous to i_clk
- i_vsync  in  1  vsync from vga_sync_pulse; 1 during active rows, 0 during vertical blanking
- o_pattern  out  3  pattern code to test_pattern_gen i_pattern
- o_pattern_changed  out  1  one-cycle pulse in the cycle o_pattern takes a new value
- o_sel_stable  out  2  debounced select code {sel0, sel1}

Behaviour:
- Reset, asynchronous, all registers:
  - o_pattern = 3'b001; o_pattern_changed = 0; o_sel_stable = 2'b00.
  - Synchroniser flops = 0; candidate = 2'b00; counter = 0; vsync history register = 0; state = S_IDLE.
- Synchroniser: two flops per select input.
- Debounce:
  - sync_code = {sel0_sync, sel1_sync}.
  - If sync_code != candidate: candidate <= sync_code, counter <= 0.
  - Otherwise the counter increments and saturates at DEBOUNCE_CYCLES-1.
  - When the counter is at DEBOUNCE_CYCLES-1 and candidate != o_sel_stable: o_sel_stable <= candidate.
  - Any glitch shorter than DEBOUNCE_CYCLES clocks never reaches o_sel_stable.
- Mapping (combinational, from o_sel_stable): 00->3'b001, 01->3'b010, 10->3'b100, 11->3'b101.
- Blank edge detect:
  - vs_d <= i_vsync each cycle.
  - blank_start = vs_d & ~i_vsync, i.e. the first cycle of vertical blanking.
- FSM states:
  - S_IDLE: o_sel_stable equals the applied code. On mismatch -> S_PENDING.
  - S_PENDING:
    - If o_sel_stable returns to the applied code -> S_IDLE, no pulse.
    - Else on blank_start -> S_APPLY.
    - A further change of o_sel_stable while pending replaces the pending value; the latest value wins.
  - S_APPLY (exactly one cycle): o_pattern <= map(o_sel_stable); applied code <= o_sel_stable; o_pattern_changed = 1 in this cycle; -> S_IDLE.
  - If o_sel_stable has changed again by the S_APPLY cycle, the value present in that cycle is the one applied; S_IDLE then re-detects any later mismatch.
- Latency, select edge to o_pattern: 2 (sync) + DEBOUNCE_CYCLES + 1 (stable reg) + wait for blank_start + 1.
- Simultaneous blank_start and entry into S_PENDING: the edge is not seen; the change waits for the next frame.
- i_vsync held constant (no frames): the change stays pending indefinitely; o_pattern holds.
- Reset mid-debounce or mid-pending: all state is discarded; o_pattern returns to 3'b001 immediately.

Optional Feature:
- Macro PATSEL_FRAME_ALIGN_EN.
- Defined: frame-aligned behaviour as above.
- Undefined:
  - S_PENDING moves to S_APPLY on the cycle after entry, without waiting for blank_start.
  - i_vsync is ignored and the vs_d register is not built.
  - Latency = 2 + DEBOUNCE_CYCLES + 3 clocks.

Test Plan (DEBOUNCE_CYCLES=16, vsync period 200 clocks, vsync low for 20 clocks):
- Reset asserted mid-run -> o_pattern=3'b001, o_sel_stable=00, o_pattern_changed=0 with no clock edge.
- {sel0,sel1}: 00->10, held -> o_sel_stable=10 at clock 19 after the edge; o_pattern=3'b100 only in the cycle after the next i_vsync fall; single o_pattern_changed pulse.
- Glitch sel1=1 for 10 clocks -> o_sel_stable stays 00; no pulse; o_pattern stays 3'b001.
- Select 00->01, then 01->11 before blanking -> one pulse at the next blank start; o_pattern=3'b101 (3'b010 never appears).
- Select 00->01, then back to 00 before blanking -> FSM returns to S_IDLE; no pulse across two frames.
- PATSEL_FRAME_ALIGN_EN undefined, select 00->11 -> o_pattern=3'b101 exactly 21 clocks after the input edge, independent of i_vsync.
